// File: rtl/mem_arbiter.sv
// Purpose : shares one block-wide data memory between the icache (read-only) and the dcache
//           (read/write); one block transfer at a time, each requester sees its own handshake.
// Ports   : CLK/RESET; I_* icache request side; D_* dcache request side; MEM_* data memory side.
//           MEM_ARB_RR_EN defined selects round-robin on simultaneous requests, otherwise the
//           dcache wins every simultaneous request.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              CLK,
  input  logic              RESET,
  // icache side
  input  logic              I_MEM_READ,
  input  logic [ADDR_W-1:0] I_BLOCK_ADDR,
  output logic              I_BUSYWAIT,
  output logic [DATA_W-1:0] I_READDATA,
  // dcache side
  input  logic              D_MEM_READ,
  input  logic              D_MEM_WRITE,
  input  logic [ADDR_W-1:0] D_BLOCK_ADDR,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic              D_BUSYWAIT,
  output logic [DATA_W-1:0] D_READDATA,
  // data memory side
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_BLOCK_ADDR,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic              MEM_BUSYWAIT,
  input  logic [DATA_W-1:0] MEM_READDATA
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT_I   = 3'd1,
    GRANT_D   = 3'd2,
    RELEASE_I = 3'd3,
    RELEASE_D = 3'd4
  } state_t;

  state_t              state_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                seen_busy_q;

  logic                d_req;
  logic                d_wins_d;

  assign d_req = D_MEM_READ | D_MEM_WRITE;

`ifdef MEM_ARB_RR_EN
  // 1 = dcache was granted last. On a tie the requester that did not go last wins.
  logic last_grant_q;
  assign d_wins_d = d_req & (~I_MEM_READ | ~last_grant_q);
`else
  // The dcache miss belongs to the older instruction, so it always wins a tie.
  assign d_wins_d = d_req;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      seen_busy_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (d_wins_d) begin
            state_q      <= GRANT_D;
            mem_read_q   <= D_MEM_READ;
            mem_write_q  <= D_MEM_WRITE;
            addr_q       <= D_BLOCK_ADDR;
            wdata_q      <= D_WRITEDATA;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
          end else if (I_MEM_READ) begin
            state_q      <= GRANT_I;
            mem_read_q   <= 1'b1;
            mem_write_q  <= 1'b0;
            addr_q       <= I_BLOCK_ADDR;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= 1'b0;
`endif
          end
        end
        GRANT_I, GRANT_D: begin
          // The transfer only ends on a busy->idle transition of the memory; an idle
          // memory before it ever went busy has not accepted the strobe yet.
          if (!seen_busy_q) begin
            if (MEM_BUSYWAIT) seen_busy_q <= 1'b1;
          end else if (!MEM_BUSYWAIT) begin
            seen_busy_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (state_q == GRANT_I) begin
              // A requester that abandoned its read gets nothing back.
              if (I_MEM_READ) i_rdata_q <= MEM_READDATA;
              state_q <= RELEASE_I;
            end else begin
              if (mem_read_q && D_MEM_READ) d_rdata_q <= MEM_READDATA;
              state_q <= RELEASE_D;
            end
          end
        end
        RELEASE_I, RELEASE_D: state_q <= IDLE;
        default:              state_q <= IDLE;
      endcase
    end
  end

  // Each requester is stalled from request until its own release cycle, including
  // the whole time the other side holds the memory.
  assign I_BUSYWAIT = ~RESET & I_MEM_READ & (state_q != RELEASE_I);
  assign D_BUSYWAIT = ~RESET & d_req      & (state_q != RELEASE_D);

  assign I_READDATA     = i_rdata_q;
  assign D_READDATA     = d_rdata_q;
  assign MEM_READ       = mem_read_q;
  assign MEM_WRITE      = mem_write_q;
  assign MEM_BLOCK_ADDR = addr_q;
  assign MEM_WRITEDATA  = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          I_MEM_READ;
  logic [AW-1:0] I_BLOCK_ADDR;
  logic          I_BUSYWAIT;
  logic [DW-1:0] I_READDATA;
  logic          D_MEM_READ;
  logic          D_MEM_WRITE;
  logic [AW-1:0] D_BLOCK_ADDR;
  logic [DW-1:0] D_WRITEDATA;
  logic          D_BUSYWAIT;
  logic [DW-1:0] D_READDATA;
  logic          MEM_READ;
  logic          MEM_WRITE;
  logic [AW-1:0] MEM_BLOCK_ADDR;
  logic [DW-1:0] MEM_WRITEDATA;
  logic          MEM_BUSYWAIT;
  logic [DW-1:0] MEM_READDATA;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_MEM_READ(I_MEM_READ), .I_BLOCK_ADDR(I_BLOCK_ADDR),
    .I_BUSYWAIT(I_BUSYWAIT), .I_READDATA(I_READDATA),
    .D_MEM_READ(D_MEM_READ), .D_MEM_WRITE(D_MEM_WRITE), .D_BLOCK_ADDR(D_BLOCK_ADDR),
    .D_WRITEDATA(D_WRITEDATA), .D_BUSYWAIT(D_BUSYWAIT), .D_READDATA(D_READDATA),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_BLOCK_ADDR(MEM_BLOCK_ADDR),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT), .MEM_READDATA(MEM_READDATA)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event with no expectation or bound expired", name);
  endtask

  // Memory read contents: 0x10 holds A5..A5, every other block {4{4'hC, addr}}.
  function automatic logic [DW-1:0] mem_pat(input logic [AW-1:0] a);
    if (a == 28'h10) return {16{8'hA5}};
    return {4{4'hC, a}};
  endfunction

  // ---------------- memory model ----------------
  int busy_len = 2;
  int pre_dly  = 0;
  int mst;
  int mcnt;
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mst          <= 0;
      mcnt         <= 0;
      MEM_BUSYWAIT <= 1'b0;
      MEM_READDATA <= '0;
    end else begin
      case (mst)
        0: if (MEM_READ || MEM_WRITE) begin
             if (pre_dly > 0) begin mst <= 1; mcnt <= pre_dly - 1; end
             else begin MEM_BUSYWAIT <= 1'b1; mcnt <= busy_len - 1; mst <= 2; end
           end
        1: if (mcnt == 0) begin MEM_BUSYWAIT <= 1'b1; mcnt <= busy_len - 1; mst <= 2; end
           else mcnt <= mcnt - 1;
        2: if (mcnt == 0) begin
             MEM_BUSYWAIT <= 1'b0;
             mst          <= 3;
             if (MEM_READ) MEM_READDATA <= mem_pat(MEM_BLOCK_ADDR);
           end else mcnt <= mcnt - 1;
        default: if (!(MEM_READ || MEM_WRITE)) mst <= 0;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mexp_t;

  mexp_t         mq[$];
  logic [DW-1:0] iq[$];
  logic [DW-1:0] dq[$];

  logic strobe_prev = 1'b0;
  logic i_rel_prev  = 1'b0;
  logic d_rel_prev  = 1'b0;
  int   rd_cycles   = 0;
  int   i_bw_cycles = 0;

  // Memory-side monitor: every new strobe is one transfer.
  always @(negedge CLK) begin
    mexp_t e;
    if ((MEM_READ || MEM_WRITE) && !strobe_prev) begin
      if (mq.size() == 0) miss("mem_unexpected");
      else begin
        e = mq.pop_front();
        chk("mem_write", DW'(MEM_WRITE), DW'(e.wr));
        chk("mem_read", DW'(MEM_READ), DW'(!e.wr));
        chk("mem_addr", DW'(MEM_BLOCK_ADDR), DW'(e.addr));
        if (e.wr) chk("mem_wdata", MEM_WRITEDATA, e.wdata);
      end
    end
    strobe_prev <= MEM_READ | MEM_WRITE;
    if (MEM_READ) rd_cycles <= rd_cycles + 1;
    if (I_BUSYWAIT) i_bw_cycles <= i_bw_cycles + 1;
  end

  // Requester-side monitor: busywait low with request asserted is a completion.
  always @(negedge CLK) begin
    if (!RESET && I_MEM_READ && !I_BUSYWAIT) begin
      chk("i_release_one_cycle", DW'(i_rel_prev), '0);
      chk("i_release_strobes", DW'(MEM_READ | MEM_WRITE), '0);
      if (iq.size() == 0) miss("i_unexpected");
      else chk("i_readdata", I_READDATA, iq.pop_front());
      i_rel_prev <= 1'b1;
    end else i_rel_prev <= 1'b0;
    if (!RESET && (D_MEM_READ || D_MEM_WRITE) && !D_BUSYWAIT) begin
      chk("d_release_one_cycle", DW'(d_rel_prev), '0);
      chk("d_release_strobes", DW'(MEM_READ | MEM_WRITE), '0);
      if (dq.size() == 0) miss("d_unexpected");
      else chk("d_readdata", D_READDATA, dq.pop_front());
      d_rel_prev <= 1'b1;
    end else d_rel_prev <= 1'b0;
  end

  // ---------------- drivers (called at posedge+1) ----------------
  task automatic i_txn(input logic [AW-1:0] a, input bit drop, output int lat);
    I_BLOCK_ADDR = a;
    I_MEM_READ   = 1'b1;
    lat = 0;
    do begin @(posedge CLK); #1; lat++; end while (I_BUSYWAIT && lat < 200);
    if (I_BUSYWAIT) miss("i_timeout");
    @(posedge CLK); #1;
    if (drop) I_MEM_READ = 1'b0;
  endtask

  task automatic d_txn(input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input bit drop, output int lat);
    D_MEM_READ   = rd;
    D_MEM_WRITE  = !rd;
    D_BLOCK_ADDR = a;
    D_WRITEDATA  = wd;
    lat = 0;
    do begin @(posedge CLK); #1; lat++; end while (D_BUSYWAIT && lat < 200);
    if (D_BUSYWAIT) miss("d_timeout");
    @(posedge CLK); #1;
    if (drop) begin D_MEM_READ = 1'b0; D_MEM_WRITE = 1'b0; end
  endtask

  function automatic mexp_t mrd(input logic [AW-1:0] a);
    return '{wr: 1'b0, addr: a, wdata: '0};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int li, ld, c0, b0;
    logic [DW-1:0] wdat;
    wdat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    RESET = 1'b1;
    I_MEM_READ = 1'b1; I_BLOCK_ADDR = 28'h7;
    D_MEM_READ = 1'b0; D_MEM_WRITE = 1'b1; D_BLOCK_ADDR = 28'h9; D_WRITEDATA = wdat;
    @(posedge CLK); @(posedge CLK); #1;
    chk("rst_mem_read", DW'(MEM_READ), '0);
    chk("rst_mem_write", DW'(MEM_WRITE), '0);
    chk("rst_mem_addr", DW'(MEM_BLOCK_ADDR), '0);
    chk("rst_mem_wdata", MEM_WRITEDATA, '0);
    chk("rst_i_readdata", I_READDATA, '0);
    chk("rst_d_readdata", D_READDATA, '0);
    chk("rst_i_busywait", DW'(I_BUSYWAIT), '0);
    chk("rst_d_busywait", DW'(D_BUSYWAIT), '0);
    I_MEM_READ = 1'b0; D_MEM_WRITE = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;

    // 1: single dcache fill, memory busy 5 cycles
    busy_len = 5; pre_dly = 0;
    mq.push_back(mrd(28'h10));
    dq.push_back({16{8'hA5}});
    c0 = rd_cycles; b0 = i_bw_cycles;
    d_txn(1'b1, 28'h10, '0, 1'b1, ld);
    chk("t1_latency", DW'(ld), DW'(8));
    chk("t1_mem_read_cycles", DW'(rd_cycles - c0), DW'(7));
    chk("t1_i_busywait_cycles", DW'(i_bw_cycles - b0), '0);

    // 2: simultaneous icache read 0x1 and dcache write 0x2
    busy_len = 2;
`ifdef MEM_ARB_RR_EN
    mq.push_back(mrd(28'h1));
    mq.push_back('{wr: 1'b1, addr: 28'h2, wdata: wdat});
`else
    mq.push_back('{wr: 1'b1, addr: 28'h2, wdata: wdat});
    mq.push_back(mrd(28'h1));
`endif
    iq.push_back({4{32'hC000_0001}});
    dq.push_back({16{8'hA5}});
    fork
      i_txn(28'h1, 1'b1, li);
      d_txn(1'b0, 28'h2, wdat, 1'b1, ld);
    join
`ifdef MEM_ARB_RR_EN
    chk("t2_i_latency", DW'(li), DW'(5));
    chk("t2_d_latency", DW'(ld), DW'(11));
`else
    chk("t2_d_latency", DW'(ld), DW'(5));
    chk("t2_i_latency", DW'(li), DW'(11));
`endif

    // 3: back-to-back dcache fills, request held across the release edge
    mq.push_back(mrd(28'h4));
    mq.push_back(mrd(28'h8));
    dq.push_back({4{32'hC000_0004}});
    dq.push_back({4{32'hC000_0008}});
    d_txn(1'b1, 28'h4, '0, 1'b0, ld);
    chk("t3_first_latency", DW'(ld), DW'(5));
    d_txn(1'b1, 28'h8, '0, 1'b1, ld);
    chk("t3_second_latency", DW'(ld), DW'(5));

    // 4: reset two cycles into an icache grant
    busy_len = 4;
    mq.push_back(mrd(28'h30));
    I_BLOCK_ADDR = 28'h30; I_MEM_READ = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b1;
    #1;
    chk("t4_mem_read_abort", DW'(MEM_READ), '0);
    chk("t4_i_busywait", DW'(I_BUSYWAIT), '0);
    chk("t4_i_readdata", I_READDATA, '0);
    @(posedge CLK); #1;
    I_MEM_READ = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    mq.push_back(mrd(28'h30));
    iq.push_back({4{32'hC000_0030}});
    i_txn(28'h30, 1'b1, li);
    chk("t4_reissue_latency", DW'(li), DW'(7));

    // 5: memory raises busy one cycle after the strobe
    busy_len = 3; pre_dly = 1;
    mq.push_back(mrd(28'h50));
    dq.push_back({4{32'hC000_0050}});
    d_txn(1'b1, 28'h50, '0, 1'b1, ld);
    chk("t5_latency", DW'(ld), DW'(7));
    pre_dly = 0;

    // 6: icache held continuously while the dcache keeps re-requesting
    busy_len = 2;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
`ifdef MEM_ARB_RR_EN
    mq.push_back(mrd(28'h200)); mq.push_back(mrd(28'h100));
    mq.push_back(mrd(28'h201)); mq.push_back(mrd(28'h101));
    mq.push_back(mrd(28'h202)); mq.push_back(mrd(28'h102));
`else
    mq.push_back(mrd(28'h200)); mq.push_back(mrd(28'h201)); mq.push_back(mrd(28'h202));
    mq.push_back(mrd(28'h100)); mq.push_back(mrd(28'h101)); mq.push_back(mrd(28'h102));
`endif
    for (int k = 0; k < 3; k++) begin
      iq.push_back({4{4'hC, 28'h100 + 28'(k)}});
      dq.push_back({4{4'hC, 28'h200 + 28'(k)}});
    end
    fork
      begin
        i_txn(28'h100, 1'b0, li);
        i_txn(28'h101, 1'b0, li);
        i_txn(28'h102, 1'b1, li);
      end
      begin
        d_txn(1'b1, 28'h200, '0, 1'b0, ld);
        d_txn(1'b1, 28'h201, '0, 1'b0, ld);
        d_txn(1'b1, 28'h202, '0, 1'b1, ld);
      end
    join
    repeat (3) @(posedge CLK);
    #1;
    chk("end_mem_queue_empty", DW'(mq.size()), '0);
    chk("end_i_queue_empty", DW'(iq.size()), '0);
    chk("end_d_queue_empty", DW'(dq.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
